// File: rtl/dds_phase_acc.sv
// rtl/dds_phase_acc.sv - DDS phase accumulator: programmable FTW, modulus wrap, phase offset, truncation
// Optional LFSR dither below the truncation point when DDS_PHASE_DITHER_EN is defined.
module dds_phase_acc #(
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 12,
  parameter bit UPD_AT_WRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [ACC_W-1:0] ftw_i,
  input  logic             ftw_ld_i,
  input  logic [ACC_W-1:0] mod_i,
  input  logic [ACC_W-1:0] pof_i,
  output logic [OUT_W-1:0] phase_o,
  output logic             phase_vld_o,
  output logic             wrap_o,
  output logic             ftw_busy_o,
  output logic             err_o
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_ftw_act;
  logic [ACC_W-1:0] r_ftw_pend;
  logic             r_busy;
  logic             r_err;
  logic             r_upd_d;
  logic             r_wrap_d;
  logic             r_vld;
  logic             r_wrap;
  logic [OUT_W-1:0] r_phase;

  logic             w_mod_en;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_sum_red;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_acc_wrap;
  logic             w_upd;
  logic             w_apply;
  logic             w_err_cmp;
  logic [ACC_W:0]   w_psum;
  logic [ACC_W:0]   w_psum_red;
  logic [ACC_W-1:0] w_p;
  logic [ACC_W-1:0] w_dith;
  logic [ACC_W-1:0] w_pd;

  assign w_mod_en  = |mod_i;
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_ftw_act};
  assign w_sum_red = w_sum - {1'b0, mod_i};

  always_comb begin
    w_acc_nxt  = w_sum[ACC_W-1:0];
    w_acc_wrap = w_sum[ACC_W];
    if (w_mod_en) begin
      if (w_sum >= {1'b0, mod_i}) begin
        w_acc_nxt  = w_sum_red[ACC_W-1:0];
        w_acc_wrap = 1'b1;
      end else begin
        w_acc_wrap = 1'b0;
      end
    end
  end

  assign w_upd     = en_i & ~clr_i & ~r_err;
  // With UPD_AT_WRAP the new FTW only takes effect across a wrap, keeping phase continuous.
  assign w_apply   = w_upd & r_busy & (!UPD_AT_WRAP || w_acc_wrap);
  assign w_err_cmp = w_mod_en & ((r_ftw_act >= mod_i) | (pof_i >= mod_i));

  assign w_psum     = {1'b0, r_acc} + {1'b0, pof_i};
  assign w_psum_red = w_psum - {1'b0, mod_i};
  assign w_p        = (w_mod_en && (w_psum >= {1'b0, mod_i})) ? w_psum_red[ACC_W-1:0]
                                                              : w_psum[ACC_W-1:0];
  assign w_pd       = w_p + w_dith;

`ifdef DDS_PHASE_DITHER_EN
  localparam int DITH_W = (ACC_W - OUT_W > 16) ? 16 : (ACC_W - OUT_W);
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (w_upd) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  generate
    if (DITH_W >= 1) begin : g_dith
      assign w_dith = w_mod_en ? '0 : {{(ACC_W-DITH_W){1'b0}}, r_lfsr[DITH_W-1:0]};
    end else begin : g_no_dith
      assign w_dith = '0;
    end
  endgenerate
`else
  assign w_dith = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_ftw_act  <= '0;
      r_ftw_pend <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_upd_d    <= 1'b0;
      r_wrap_d   <= 1'b0;
      r_vld      <= 1'b0;
      r_wrap     <= 1'b0;
      r_phase    <= '0;
    end else begin
      r_err    <= w_err_cmp;
      r_upd_d  <= w_upd;
      r_wrap_d <= w_upd & w_acc_wrap;
      r_vld    <= r_upd_d & ~w_err_cmp;
      r_wrap   <= r_upd_d & r_wrap_d & ~w_err_cmp;
      if (r_upd_d && !w_err_cmp) begin
        r_phase <= w_pd[ACC_W-1 -: OUT_W];
      end
      if (clr_i) begin
        r_acc  <= '0;
        r_busy <= 1'b0;
        if (ftw_ld_i) begin
          r_ftw_act  <= ftw_i;
          r_ftw_pend <= ftw_i;
        end else if (r_busy) begin
          r_ftw_act <= r_ftw_pend;
        end
      end else begin
        if (r_err) begin
          r_acc <= '0;
        end else if (w_upd) begin
          r_acc <= w_acc_nxt;
        end
        // Apply takes the old pending value; a same-edge load stays pending.
        if (w_apply) begin
          r_ftw_act <= r_ftw_pend;
        end
        if (ftw_ld_i) begin
          r_ftw_pend <= ftw_i;
          r_busy     <= 1'b1;
        end else if (w_apply) begin
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign phase_o     = r_phase;
  assign phase_vld_o = r_vld;
  assign wrap_o      = r_wrap;
  assign ftw_busy_o  = r_busy;
  assign err_o       = r_err;

endmodule

// File: tb/tb_dds_phase_acc.sv
// tb/tb_dds_phase_acc.sv - randomized and directed bench for dds_phase_acc against an arithmetic reference model
// Three instances: (8,4,wrap-apply), (8,8,wrap-apply), (8,8,immediate-apply); DDS_PHASE_DITHER_EN undefined.
module tb_dds_phase_acc;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] ftw;
  logic       ftw_ld;
  logic [7:0] modulus;
  logic [7:0] pof;

  logic [3:0] ph_a;
  logic [7:0] ph_b;
  logic [7:0] ph_c;
  logic       vld_a, vld_b, vld_c;
  logic       wr_a, wr_b, wr_c;
  logic       busy_a, busy_b, busy_c;
  logic       err_a, err_b, err_c;

  int n_vec = 0;
  int n_mis = 0;

  int OW[3]  = '{4, 8, 8};
  int UAW[3] = '{1, 1, 0};

  int m_acc[3], m_act[3], m_pend[3], m_busy[3], m_err[3];
  int m_updd[3], m_wrapd[3], m_ph[3], m_vld[3], m_wr[3];

  int col_ph[3][16];
  int col_wr[3][16];
  int col_n[3];
  int exp_ph[8];
  int exp_wr[8];

  dds_phase_acc #(.ACC_W(8), .OUT_W(4), .UPD_AT_WRAP(1'b1)) u_a (
    .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .ftw_i(ftw), .ftw_ld_i(ftw_ld),
    .mod_i(modulus), .pof_i(pof), .phase_o(ph_a), .phase_vld_o(vld_a), .wrap_o(wr_a),
    .ftw_busy_o(busy_a), .err_o(err_a));

  dds_phase_acc #(.ACC_W(8), .OUT_W(8), .UPD_AT_WRAP(1'b1)) u_b (
    .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .ftw_i(ftw), .ftw_ld_i(ftw_ld),
    .mod_i(modulus), .pof_i(pof), .phase_o(ph_b), .phase_vld_o(vld_b), .wrap_o(wr_b),
    .ftw_busy_o(busy_b), .err_o(err_b));

  dds_phase_acc #(.ACC_W(8), .OUT_W(8), .UPD_AT_WRAP(1'b0)) u_c (
    .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .ftw_i(ftw), .ftw_ld_i(ftw_ld),
    .mod_i(modulus), .pof_i(pof), .phase_o(ph_c), .phase_vld_o(vld_c), .wrap_o(wr_c),
    .ftw_busy_o(busy_c), .err_o(err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_ph(input int i);
    if (i == 0) return {28'b0, ph_a};
    if (i == 1) return {24'b0, ph_b};
    return {24'b0, ph_c};
  endfunction

  function automatic logic [31:0] get_bit(input int i, input int sel);
    logic [2:0] v;
    case (sel)
      0:       v = {vld_c, vld_b, vld_a};
      1:       v = {wr_c, wr_b, wr_a};
      2:       v = {busy_c, busy_b, busy_a};
      default: v = {err_c, err_b, err_a};
    endcase
    return {31'b0, v[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_act[i] = 0; m_pend[i] = 0; m_busy[i] = 0; m_err[i] = 0;
      m_updd[i] = 0; m_wrapd[i] = 0; m_ph[i] = 0; m_vld[i] = 0; m_wr[i] = 0;
    end
  endtask

  // Reference: one clock edge of the phase accumulator, in plain integer arithmetic.
  task automatic model_step();
    int md, po, fw;
    md = int'(modulus);
    po = int'(pof);
    fw = int'(ftw);
    for (int i = 0; i < 3; i++) begin
      int  sum, nacc, p, errc, vld, upd, wr;
      errc = (md != 0) && (m_act[i] >= md || po >= md);
      upd  = en && !clr && (m_err[i] == 0);
      sum  = m_acc[i] + m_act[i];
      if (md == 0) begin
        wr = (sum > 255); nacc = sum % 256;
      end else if (sum >= md) begin
        wr = 1; nacc = (sum - md) % 256;
      end else begin
        wr = 0; nacc = sum;
      end
      p = m_acc[i] + po;
      if (md != 0 && p >= md) p = p - md;
      p = p % 256;
      vld = (m_updd[i] != 0) && (errc == 0);
      if (vld != 0) m_ph[i] = p >> (8 - OW[i]);
      m_vld[i] = vld;
      m_wr[i]  = (vld != 0) && (m_wrapd[i] != 0);
      if (clr) begin
        m_acc[i] = 0;
        if (ftw_ld) m_act[i] = fw;
        else if (m_busy[i] != 0) m_act[i] = m_pend[i];
        m_busy[i] = 0;
      end else begin
        if (m_err[i] != 0) m_acc[i] = 0;
        else if (upd != 0) m_acc[i] = nacc;
        if (upd != 0 && m_busy[i] != 0 && (UAW[i] == 0 || wr != 0)) begin
          m_act[i]  = m_pend[i];
          m_busy[i] = 0;
        end
        if (ftw_ld) begin
          m_pend[i] = fw;
          m_busy[i] = 1;
        end
      end
      m_err[i]   = errc;
      m_updd[i]  = upd;
      m_wrapd[i] = (upd != 0) && (wr != 0);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("phase%0d", i), get_ph(i), m_ph[i]);
      chk($sformatf("vld%0d", i), get_bit(i, 0), m_vld[i]);
      chk($sformatf("wrap%0d", i), get_bit(i, 1), m_wr[i]);
      chk($sformatf("busy%0d", i), get_bit(i, 2), m_busy[i]);
      chk($sformatf("err%0d", i), get_bit(i, 3), m_err[i]);
      if (get_bit(i, 0) == 1 && col_n[i] < 16) begin
        col_ph[i][col_n[i]] = int'(get_ph(i));
        col_wr[i][col_n[i]] = int'(get_bit(i, 1));
        col_n[i]++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_col();
    for (int i = 0; i < 3; i++) col_n[i] = 0;
  endtask

  task automatic exp_seq(input string tag, input int i, input int n);
    chk({tag, "_count"}, col_n[i], n);
    for (int k = 0; k < n && k < col_n[i]; k++) begin
      chk($sformatf("%s_phase%0d", tag, k), col_ph[i][k], exp_ph[k]);
      chk($sformatf("%s_wrap%0d", tag, k), col_wr[i][k], exp_wr[k]);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; ftw = '0; ftw_ld = 1'b0; modulus = '0; pof = '0;
    model_reset();
    clear_col();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Reset mid-run with a pending FTW
    ftw = 8'h30; ftw_ld = 1'b1; en = 1'b1; cyc();
    ftw_ld = 1'b0; cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_phase", get_ph(i), 0);
      chk("rst_vld", get_bit(i, 0), 0);
      chk("rst_wrap", get_bit(i, 1), 0);
      chk("rst_busy", get_bit(i, 2), 0);
      chk("rst_err", get_bit(i, 3), 0);
    end
    en = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    cyc();
    chk("rst_busy_after", get_bit(0, 2), 0);
    ftw = 8'h50; ftw_ld = 1'b1; clr = 1'b1; cyc();
    ftw_ld = 1'b0; clr = 1'b0; en = 1'b1; clear_col(); cyc();
    en = 1'b0; cyc();
    exp_ph = '{5, 0, 0, 0, 0, 0, 0, 0}; exp_wr = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_seq("first", 0, 1);

    // Natural wrap
    ftw = 8'h40; ftw_ld = 1'b1; clr = 1'b1; cyc();
    ftw_ld = 1'b0; clr = 1'b0; en = 1'b1; clear_col();
    repeat (5) cyc();
    en = 1'b0; cyc();
    exp_ph = '{4, 8, 12, 0, 4, 0, 0, 0}; exp_wr = '{0, 0, 0, 1, 0, 0, 0, 0};
    exp_seq("natwrap", 0, 5);

    // Modulus wrap, then phase offset
    modulus = 8'd10; ftw = 8'd3; ftw_ld = 1'b1; clr = 1'b1; cyc();
    ftw_ld = 1'b0; clr = 1'b0; en = 1'b1; clear_col();
    repeat (8) cyc();
    en = 1'b0; cyc();
    exp_ph = '{3, 6, 9, 2, 5, 8, 1, 0}; exp_wr = '{0, 0, 0, 1, 0, 0, 1, 0};
    exp_seq("modwrap", 1, 7);
    pof = 8'd4; clr = 1'b1; cyc();
    clr = 1'b0; en = 1'b1; clear_col();
    repeat (4) cyc();
    en = 1'b0; cyc();
    exp_ph = '{7, 0, 3, 6, 0, 0, 0, 0}; exp_wr = '{0, 0, 0, 1, 0, 0, 0, 0};
    exp_seq("offset", 1, 4);

    // FTW update at wrap vs immediate
    modulus = 8'd0; pof = 8'd0; ftw = 8'h40; ftw_ld = 1'b1; clr = 1'b1; cyc();
    ftw_ld = 1'b0; clr = 1'b0; en = 1'b1; clear_col();
    for (int k = 0; k < 6; k++) begin
      ftw_ld = (k == 1);
      ftw    = (k == 1) ? 8'h20 : 8'h40;
      cyc();
      if (k == 2) chk("upd_busy_held", get_bit(1, 2), 1);
      if (k == 3) chk("upd_busy_wrap", get_bit(1, 2), 0);
    end
    ftw_ld = 1'b0; en = 1'b0; cyc();
    exp_ph = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h20, 8'h40, 0, 0};
    exp_wr = '{0, 0, 0, 1, 0, 0, 0, 0};
    exp_seq("updwrap", 1, 6);
    exp_ph = '{8'h40, 8'h80, 8'hC0, 8'hE0, 8'h00, 8'h20, 0, 0};
    exp_wr = '{0, 0, 0, 0, 1, 0, 0, 0};
    exp_seq("updnow", 2, 6);

    // Clear with enable and a pending FTW
    ftw = 8'h10; ftw_ld = 1'b1; cyc();
    ftw_ld = 1'b0; clr = 1'b1; en = 1'b1; clear_col(); cyc();
    chk("clr_busy", get_bit(1, 2), 0);
    clr = 1'b0;
    repeat (2) cyc();
    en = 1'b0; cyc();
    exp_ph = '{8'h10, 8'h20, 0, 0, 0, 0, 0, 0}; exp_wr = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_seq("clear", 1, 2);

    // Configuration error and recovery
    modulus = 8'd10; ftw = 8'd12; ftw_ld = 1'b1; clr = 1'b1; cyc();
    ftw_ld = 1'b0; clr = 1'b0; en = 1'b1; clear_col();
    repeat (3) cyc();
    chk("err_level", get_bit(1, 3), 1);
    chk("err_novld", col_n[1], 0);
    ftw = 8'd2; ftw_ld = 1'b1; clr = 1'b1; en = 1'b0; cyc();
    ftw_ld = 1'b0; clr = 1'b0; en = 1'b1; clear_col();
    repeat (6) cyc();
    en = 1'b0; cyc();
    exp_ph = '{2, 4, 6, 8, 0, 0, 0, 0}; exp_wr = '{0, 0, 0, 0, 1, 0, 0, 0};
    exp_seq("errclr", 1, 5);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) modulus = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      en     = ($urandom_range(0, 3) != 0);
      clr    = ($urandom_range(0, 15) == 0);
      ftw_ld = ($urandom_range(0, 7) == 0);
      ftw    = (modulus != 0) ? 8'($urandom_range(0, int'(modulus))) : 8'($urandom);
      pof    = (modulus != 0) ? 8'($urandom_range(0, int'(modulus))) : 8'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
